ctr_seq_checker: RTL and testbench
==================================

Name: ctr_seq_checker

Overview:
Receive-side checker for counter-mode block streams. It consumes the counter blocks presented to the cipher, one per valid cycle. Each block is checked against the increment of the previously accepted block, using inc32 or inc64 per static mode. The block tracks lock, counts sequence errors and flags counter wrap-around. It sits on the decrypt/verify datapath and monitors the counter generator output.

Parameters:
NB_BLOCK, 128, counter block width; any other value is an illegal configuration.
NB_MODE, 2, width of the static mode field.
NB_ERR_CNT, 16, width of the saturating error counter.
N_LOCK, 4, consecutive matches required to enter LOCKED (range 1..15).
N_UNLOCK, 3, consecutive mismatches in LOCKED that drop lock (range 1..15).

Ports:
i_clock  in  1  clock.
i_async_reset  in  1  asynchronous, active-high reset.
i_block  in  NB_BLOCK  received counter block.
i_valid  in  1  i_block is valid this cycle.
i_sop  in  1  qualified by i_valid; block is a fresh initial counter block: load it as reference, no check.
i_rf_static_mode  in  NB_MODE  0 = INC32, 1 = INC64, 2/3 = checking disabled.
i_rf_static_enable  in  1  checker enable.
i_clear_err_cnt  in  1  synchronous clear of o_err_count.
o_locked  out  1  high in LOCKED state.
o_err  out  1  one-cycle pulse per detected mismatch.
o_wrap  out  1  one-cycle pulse when the accepted block's counter field is all-ones.
o_err_count  out  NB_ERR_CNT  saturating mismatch count.
o_expected_block  out  NB_BLOCK  next expected block.

Behaviour:
- Reset clears all outputs and internal registers. State = IDLE. Clock is i_clock; reset is asynchronous, active-high.
- All outputs are registered. Latency from the accepted i_block to o_err / o_wrap / o_locked / o_expected_block is 1 cycle.
- Next block: INC32 = {blk[127:32], blk[31:0]+1} mod 2^32. INC64 = {blk[127:64], blk[63:0]+1} mod 2^64. Head bits are never carried into.
- Match: i_block equals the expected block over the compared bits (see Optional Feature).
- Accepted block: i_valid=1 with enable=1 and mode in {0,1}. After every accepted block, expected <= next(i_block), including after a mismatch (resync on received).
- IDLE: first accepted block, with or without sop, loads the reference and goes to HUNT with good_cnt=0. No check, no o_err.
- HUNT:
  - Match: good_cnt++. When good_cnt reaches N_LOCK, go to LOCKED with bad_cnt=0.
  - Mismatch: good_cnt=0, reference reloaded. No o_err and no count in HUNT.
- LOCKED:
  - Match: bad_cnt=0.
  - Mismatch: o_err pulses, o_err_count++, bad_cnt++. When bad_cnt reaches N_UNLOCK, go to HUNT with good_cnt=0.
- i_sop on an accepted block in HUNT or LOCKED: reference reload only. No check; state, good_cnt and bad_cnt unchanged.
- o_wrap: pulses for an accepted block whose low 32 bits (INC32) or low 64 bits (INC64) are all-ones, in any state.
- o_err_count:
  - Saturates at all-ones.
  - i_clear_err_cnt together with an error in the same cycle gives 1.
  - Held (not cleared) when enable is low.
- Enable low, or mode in {2,3}: synchronous return to IDLE. o_locked=0, no pulses, input ignored.
- Mode change while enabled: detected against the registered mode. Forces IDLE that cycle; the block in that cycle is ignored.
- i_valid=0: no state change, pulses low.

Optional Feature:
CTR_SEQ_CHECK_HEAD_EN.
- Defined: match compares all NB_BLOCK bits, so a corrupted head (nonce/IV) is an error.
- Undefined: only the counter tail is compared (32 or 64 bits); head bits are don't-care.
- Wrap detection is identical in both builds.

Decomposition:
- Shared package (ctr_seq_pkg): mode encodings MODE_INC32=0, MODE_INC64=1, MODE_PRBS=2; NB_32=32, NB_64=64; state encodings ST_IDLE, ST_HUNT, ST_LOCKED (2 bits).
- One combinational sub-module, ctr_seq_next_block: block plus mode in, next block and tail-all-ones flag out.
- The compare mask logic stays in the top module.

Test Plan:
- Lock: enable=1, mode=0, sop block 0x...0000_0000_0000_0005, then 0x...06 through 0x...09 (N_LOCK=4) -> o_locked rises the cycle after 0x...09; o_err never asserts.
- Error and resync: locked, send 0x...0A, 0x...10, 0x...11 -> one o_err pulse after 0x...10, count=1; 0x...11 matches, lock held.
- Unlock: locked, 3 consecutive mismatched blocks -> 3 o_err pulses, count=3; o_locked falls after the third. A subsequent 4-block good run relocks.
- Wrap: mode=0, block low32=0xFFFF_FFFF, head=H -> o_wrap pulse; expected={H,0x0000_0000}. Mode=1 with low64 all-ones -> head also unchanged.
- Head check: locked, block with correct tail and flipped bit 100 -> o_err pulse only when CTR_SEQ_CHECK_HEAD_EN is defined.
- Boundaries:
  - Reset asserted mid-LOCKED -> all outputs 0 immediately.
  - Count at 0xFFFF plus error -> stays 0xFFFF.
  - Clear plus error same cycle -> count=1.
  - Mode 0->1 while enabled -> IDLE, o_locked=0.

Source files
------------

// File: rtl/ctr_seq_pkg.sv
// Shared definitions for the counter-sequence checker: mode and state
// encodings and the counter-field widths.
package ctr_seq_pkg;

  localparam int NB_32 = 32;
  localparam int NB_64 = 64;

  localparam logic [1:0] MODE_INC32 = 2'd0;
  localparam logic [1:0] MODE_INC64 = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Modes 0 and 1 are counter modes; anything at or above PRBS disables checking.
  function automatic logic mode_is_ctr(input logic [1:0] mode);
    return mode < MODE_PRBS;
  endfunction

endpackage

// File: rtl/ctr_seq_next_block.sv
// Combinational counter increment: produces the block that should follow
// i_block under inc32/inc64, and flags an all-ones counter tail (wrap).
// The head above the counter field is passed through untouched.
module ctr_seq_next_block
  import ctr_seq_pkg::*;
#(
  parameter int NB_BLOCK = 128,
  parameter int NB_MODE  = 2
) (
  input  logic [NB_BLOCK-1:0] i_block,
  input  logic [NB_MODE-1:0]  i_mode,
  output logic [NB_BLOCK-1:0] o_next_block,
  output logic                o_tail_ones
);

  // Increment only the counter tail selected by mode; no carry into the head.
  always_comb begin
    o_next_block = i_block;
    o_tail_ones  = 1'b0;
    if (i_mode == NB_MODE'(MODE_INC64)) begin
      o_next_block[NB_64-1:0] = i_block[NB_64-1:0] + NB_64'(1);
      o_tail_ones             = &i_block[NB_64-1:0];
    end else begin
      o_next_block[NB_32-1:0] = i_block[NB_32-1:0] + NB_32'(1);
      o_tail_ones             = &i_block[NB_32-1:0];
    end
  end

endmodule

// File: rtl/ctr_seq_checker.sv
// Receive-side counter-sequence checker. Tracks IDLE/HUNT/LOCKED, pulses
// o_err on mismatches while locked, counts them (saturating) and flags
// counter wrap. Every accepted block resyncs the expected block.
// Build option: CTR_SEQ_CHECK_HEAD_EN -- when defined the full block
// (head included) is compared; otherwise only the counter tail.
module ctr_seq_checker
  import ctr_seq_pkg::*;
#(
  parameter int NB_BLOCK   = 128,
  parameter int NB_MODE    = 2,
  parameter int NB_ERR_CNT = 16,
  parameter int N_LOCK     = 4,
  parameter int N_UNLOCK   = 3
) (
  input  logic                  i_clock,
  input  logic                  i_async_reset,
  input  logic [NB_BLOCK-1:0]   i_block,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic [NB_MODE-1:0]    i_rf_static_mode,
  input  logic                  i_rf_static_enable,
  input  logic                  i_clear_err_cnt,
  output logic                  o_locked,
  output logic                  o_err,
  output logic                  o_wrap,
  output logic [NB_ERR_CNT-1:0] o_err_count,
  output logic [NB_BLOCK-1:0]   o_expected_block
);

  localparam logic [NB_BLOCK-1:0] MASK32 = {{(NB_BLOCK-NB_32){1'b0}}, {NB_32{1'b1}}};
  localparam logic [NB_BLOCK-1:0] MASK64 = {{(NB_BLOCK-NB_64){1'b0}}, {NB_64{1'b1}}};

  state_t                  state_q, state_d;
  logic [3:0]              good_q, good_d, good_inc;
  logic [3:0]              bad_q, bad_d, bad_inc;
  logic [NB_BLOCK-1:0]     exp_d;
  logic [NB_MODE-1:0]      mode_q;
  logic                    err_d, wrap_d;
  logic [NB_ERR_CNT-1:0]   cnt_base, cnt_d;
  logic [NB_BLOCK-1:0]     next_block;
  logic                    tail_ones;
  logic [NB_BLOCK-1:0]     cmp_mask;
  logic                    active, mode_chg, match;

  ctr_seq_next_block #(
    .NB_BLOCK (NB_BLOCK),
    .NB_MODE  (NB_MODE)
  ) u_next_block (
    .i_block      (i_block),
    .i_mode       (i_rf_static_mode),
    .o_next_block (next_block),
    .o_tail_ones  (tail_ones)
  );

  assign active   = i_rf_static_enable && mode_is_ctr(2'(i_rf_static_mode));
  assign mode_chg = (i_rf_static_mode != mode_q);
  assign good_inc = good_q + 4'd1;
  assign bad_inc  = bad_q + 4'd1;

  // Select which bits of the block take part in the match.
  always_comb begin
`ifdef CTR_SEQ_CHECK_HEAD_EN
    cmp_mask = '1;
`else
    cmp_mask = (i_rf_static_mode == NB_MODE'(MODE_INC64)) ? MASK64 : MASK32;
`endif
  end

  assign match = ((i_block ^ o_expected_block) & cmp_mask) == '0;

  // Next-state, counters, reference and pulse decode for one accepted block.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    exp_d   = o_expected_block;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (!active || mode_chg) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
    end else if (i_valid) begin
      wrap_d = tail_ones;
      exp_d  = next_block;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          good_d  = '0;
        end
        ST_HUNT: begin
          if (!i_sop) begin
            if (match) begin
              good_d = good_inc;
              if (good_inc == 4'(N_LOCK)) begin
                state_d = ST_LOCKED;
                bad_d   = '0;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (!i_sop) begin
            if (match) begin
              bad_d = '0;
            end else begin
              err_d = 1'b1;
              bad_d = bad_inc;
              if (bad_inc == 4'(N_UNLOCK)) begin
                state_d = ST_HUNT;
                good_d  = '0;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end
  end

  // Saturating error counter; clear takes effect only while enabled and an
  // error in the same cycle counts on top of the cleared value.
  always_comb begin
    cnt_base = (i_rf_static_enable && i_clear_err_cnt) ? '0 : o_err_count;
    cnt_d    = cnt_base;
    if (err_d && (cnt_base != '1)) begin
      cnt_d = cnt_base + NB_ERR_CNT'(1);
    end
  end

  // State, reference and registered outputs.
  always_ff @(posedge i_clock or posedge i_async_reset) begin
    if (i_async_reset) begin
      state_q          <= ST_IDLE;
      good_q           <= '0;
      bad_q            <= '0;
      mode_q           <= '0;
      o_expected_block <= '0;
      o_err            <= 1'b0;
      o_wrap           <= 1'b0;
      o_locked         <= 1'b0;
      o_err_count      <= '0;
    end else begin
      state_q          <= state_d;
      good_q           <= good_d;
      bad_q            <= bad_d;
      mode_q           <= i_rf_static_mode;
      o_expected_block <= exp_d;
      o_err            <= err_d;
      o_wrap           <= wrap_d;
      o_locked         <= (state_d == ST_LOCKED);
      o_err_count      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ctr_seq_checker.sv
// Bench for ctr_seq_checker: directed scenarios followed by random traffic,
// all compared against a behavioural model of the sequence rules.
module tb_ctr_seq_checker;

  localparam int NB      = 128;
  localparam int NB_ERR  = 8;
  localparam int NL      = 4;
  localparam int NU      = 3;
  localparam int CNT_MAX = (1 << NB_ERR) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     blk;
  logic              valid, sop, en, clr;
  logic [1:0]        mode;
  logic              o_locked, o_err, o_wrap;
  logic [NB_ERR-1:0] o_err_count;
  logic [NB-1:0]     o_expected_block;

  ctr_seq_checker #(
    .NB_BLOCK   (NB),
    .NB_MODE    (2),
    .NB_ERR_CNT (NB_ERR),
    .N_LOCK     (NL),
    .N_UNLOCK   (NU)
  ) dut (
    .i_clock            (clk),
    .i_async_reset      (rst),
    .i_block            (blk),
    .i_valid            (valid),
    .i_sop              (sop),
    .i_rf_static_mode   (mode),
    .i_rf_static_enable (en),
    .i_clear_err_cnt    (clr),
    .o_locked           (o_locked),
    .o_err              (o_err),
    .o_wrap             (o_wrap),
    .o_err_count        (o_err_count),
    .o_expected_block   (o_expected_block)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference model state
  bit           m_have_ref, m_locked, m_err, m_wrap;
  int           m_good, m_bad, m_cnt;
  logic [127:0] m_exp;
  logic [1:0]   m_prev_mode;

  function automatic logic [127:0] tail_mask(input logic [1:0] md);
    return (md == 2'd1) ? {64'h0, {64{1'b1}}} : {96'h0, {32{1'b1}}};
  endfunction

  function automatic bit blocks_match(input logic [127:0] a, input logic [127:0] b,
                                      input logic [1:0] md);
`ifdef CTR_SEQ_CHECK_HEAD_EN
    return a == b;
`else
    return (a & tail_mask(md)) == (b & tail_mask(md));
`endif
  endfunction

  task automatic model_reset();
    m_have_ref = 0; m_locked = 0; m_err = 0; m_wrap = 0;
    m_good = 0; m_bad = 0; m_cnt = 0; m_exp = '0; m_prev_mode = 2'd0;
  endtask

  task automatic model_step();
    logic [127:0] msk;
    bit           act, mt;
    m_err  = 0;
    m_wrap = 0;
    act    = en && (mode < 2'd2);
    if (!act || mode != m_prev_mode) begin
      m_have_ref = 0; m_locked = 0; m_good = 0; m_bad = 0;
    end else if (valid) begin
      msk    = tail_mask(mode);
      m_wrap = ((blk & msk) == msk);
      if (!m_have_ref) begin
        m_have_ref = 1;
        m_good     = 0;
      end else if (!sop) begin
        mt = blocks_match(blk, m_exp, mode);
        if (!m_locked) begin
          if (mt) begin
            m_good++;
            if (m_good == NL) begin m_locked = 1; m_bad = 0; end
          end else m_good = 0;
        end else begin
          if (mt) m_bad = 0;
          else begin
            m_err = 1;
            m_bad++;
            if (m_bad == NU) begin m_locked = 0; m_good = 0; m_bad = 0; end
          end
        end
      end
      m_exp = (blk & ~msk) | ((blk + 128'd1) & msk);
    end
    if (en && clr) m_cnt = 0;
    if (m_err && m_cnt < CNT_MAX) m_cnt++;
    m_prev_mode = mode;
  endtask

  task automatic compare_all();
    check("locked", 128'(o_locked), 128'(m_locked));
    check("err", 128'(o_err), 128'(m_err));
    check("wrap", 128'(o_wrap), 128'(m_wrap));
    check("err_count", 128'(o_err_count), 128'(m_cnt));
    check("expected", o_expected_block, m_exp);
  endtask

  // One clock: drive at negedge, update model, sample at the next negedge.
  task automatic step(input logic v, input logic s, input logic [127:0] b);
    valid = v; sop = s; blk = b;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [127:0] tail_flip();
    return m_exp ^ (128'd1 << $urandom_range(0, 31));
  endfunction

  localparam logic [95:0] H32 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [63:0] H64 = 64'hCAFE_F00D_5555_AAAA;

  initial begin
    rst = 1'b1; valid = 0; sop = 0; blk = '0; en = 0; clr = 0; mode = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Lock on a sop block followed by four increments
    en = 1; mode = 2'd0;
    step(0, 0, '0);
    step(1, 1, {H32, 32'h5});
    for (int i = 6; i <= 8; i++) step(1, 0, {H32, 32'(i)});
    check("pre_lock", 128'(o_locked), 128'd0);
    step(1, 0, {H32, 32'h9});
    check("lock_rise", 128'(o_locked), 128'd1);

    // Single error, resync on received block
    step(1, 0, {H32, 32'hA});
    step(1, 0, {H32, 32'h10});
    check("err_pulse", 128'(o_err), 128'd1);
    check("err_cnt1", 128'(o_err_count), 128'd1);
    step(1, 0, {H32, 32'h11});
    check("resync_lock", 128'(o_locked), 128'd1);
    check("resync_noerr", 128'(o_err), 128'd0);

    // Three mismatches drop lock, four good blocks relock
    step(1, 0, {H32, 32'h20});
    step(1, 0, {H32, 32'h30});
    step(1, 0, {H32, 32'h40});
    check("unlock", 128'(o_locked), 128'd0);
    check("err_cnt4", 128'(o_err_count), 128'd4);
    for (int i = 'h41; i <= 'h44; i++) step(1, 0, {H32, 32'(i)});
    check("relock", 128'(o_locked), 128'd1);

    // 32-bit wrap on a sop block
    step(1, 1, {H32, 32'hFFFF_FFFF});
    check("wrap32", 128'(o_wrap), 128'd1);
    check("wrap32_exp", o_expected_block, {H32, 32'h0});

    // Mode change forces IDLE and ignores that block
    mode = 2'd1;
    step(1, 0, {H32, 32'h1});
    check("modechg_unlock", 128'(o_locked), 128'd0);
    step(1, 0, {H64, 64'hFFFF_FFFF_FFFF_FFFF});
    check("wrap64", 128'(o_wrap), 128'd1);
    check("wrap64_exp", o_expected_block, {H64, 64'h0});
    for (int i = 0; i < 4; i++) step(1, 0, {H64, 64'(i)});
    check("lock64", 128'(o_locked), 128'd1);

    // Corrupted head with correct tail
    step(1, 0, m_exp ^ (128'd1 << 100));
`ifdef CTR_SEQ_CHECK_HEAD_EN
    check("head_err", 128'(o_err), 128'd1);
`else
    check("head_err", 128'(o_err), 128'd0);
`endif

    // Drive the counter into saturation while staying locked
    for (int i = 0; i < 140; i++) begin
      step(1, 0, tail_flip());
      step(1, 0, tail_flip());
      step(1, 0, m_exp);
    end
    check("sat", 128'(o_err_count), 128'(CNT_MAX));

    // Clear and error in the same cycle
    clr = 1;
    step(1, 0, tail_flip());
    clr = 0;
    check("clr_plus_err", 128'(o_err_count), 128'd1);
    step(1, 0, m_exp);

    // Asynchronous reset while locked
    check("pre_reset_lock", 128'(o_locked), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_locked", 128'(o_locked), 128'd0);
    check("rst_err", 128'(o_err), 128'd0);
    check("rst_wrap", 128'(o_wrap), 128'd0);
    check("rst_cnt", 128'(o_err_count), 128'd0);
    check("rst_exp", o_expected_block, 128'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] b;
      int           kind;
      if (en ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0)) en = ~en;
      if ($urandom_range(0, 99) < 2) mode = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                                       : 2'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 49) == 0);
      kind = $urandom_range(0, 9);
      if (kind <= 6)      b = m_exp;
      else if (kind == 7) b = tail_flip();
      else if (kind == 8) b = m_exp ^ (128'd1 << $urandom_range(64, 127));
      else begin
        b = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) b[63:0] = '1;
        else b[31:0] = '1;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
